// File: rtl/miner_pkg.sv
// miner_pkg: shared constants for the nonce-search dispatcher.
// Holds register offsets, CTRL/STATUS bit positions, the controller state
// encoding and the default parameter values.
package miner_pkg;

  localparam int unsigned DEF_NUM_CORES  = 4;
  localparam int unsigned DEF_FIFO_DEPTH = 8;
  localparam int unsigned DEF_ADDR_W     = 8;

  // Byte offsets of the Wishbone registers
  localparam int unsigned REG_CTRL   = 32'h00;
  localparam int unsigned REG_STATUS = 32'h04;
  localparam int unsigned REG_NONCE  = 32'h08;
  localparam int unsigned REG_RESULT = 32'h0C;

  // CTRL bits
  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_STOP   = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  // STATUS bits
  localparam int unsigned STAT_RUNNING = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_FULL    = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2
  } state_e;

endpackage

// File: rtl/miner_result_fifo.sv
// miner_result_fifo: synchronous result FIFO with flush and occupancy count.
// A push is accepted while full when a pop happens on the same edge.
// Ports: clk/arst_n; flush clears contents; push/push_data write; pop
// removes the head; head is the current head entry; count/empty/full
// report occupancy.
module miner_result_fifo
  import miner_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_FIFO_DEPTH,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_q];
  assign count   = cnt_q;

  // Pointer/count update; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PTR_W'(1);
      if (do_pop)  rd_d = rd_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read when count says valid
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/miner_dispatch.sv
// miner_dispatch: Wishbone-controlled dispatcher for NUM_CORES nonce cores.
// Interleaves the nonce space (core i starts at NONCE_START + i), launches
// and aborts the cores, and funnels hit nonces through per-core pending
// registers and a round-robin arbiter into a result FIFO.
// Ports: clk/arst_n; wb_* classic Wishbone slave (registered ack/err/rdata);
// core_start/core_abort one-cycle pulses; core_nonce_base per-core bases;
// core_busy/core_hit/core_hit_nonce from the cores; irq level interrupt.
module miner_dispatch
  import miner_pkg::*;
#(
  parameter int unsigned NUM_CORES  = DEF_NUM_CORES,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      wb_cycle,
  input  logic                      wb_strobe,
  input  logic                      wb_we,
  input  logic [3:0]                wb_sel,
  input  logic [ADDR_W-1:0]         wb_addr,
  input  logic [31:0]               wb_wdata,
  output logic                      wb_ack,
  output logic                      wb_err,
  output logic [31:0]               wb_rdata,
  output logic [NUM_CORES-1:0]      core_start,
  output logic [NUM_CORES-1:0]      core_abort,
  output logic [32*NUM_CORES-1:0]   core_nonce_base,
  input  logic [NUM_CORES-1:0]      core_busy,
  input  logic [NUM_CORES-1:0]      core_hit,
  input  logic [32*NUM_CORES-1:0]   core_hit_nonce,
  output logic                      irq
);

  localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned RA_W  = ADDR_W - 2;

  state_e                        state_q, state_d;
  logic                          run_first_q, run_first_d;
  logic                          irq_en_q, irq_en_d;
  logic [31:0]                   nonce_start_q, nonce_start_d;
  logic [NUM_CORES-1:0][31:0]    base_q, base_d;
  logic [NUM_CORES-1:0]          start_q, start_d, abort_q, abort_d;
  logic                          ack_q, ack_d, err_q, err_d, irq_q, irq_d;
  logic [31:0]                   rdata_q, rdata_d;
  logic                          ovf_q, ovf_d;
  logic [NUM_CORES-1:0]          pend_vld_q, pend_vld_d;
  logic [NUM_CORES-1:0][31:0]    pend_nonce_q, pend_nonce_d;
  logic [IDX_W-1:0]              rr_q, rr_d;

  logic [NUM_CORES-1:0][31:0]    hit_nonce;
  logic [RA_W-1:0]               reg_addr;
  logic sel_ctrl, sel_status, sel_nonce, sel_result, mapped;
  logic req, wr_req, rd_req, start_cmd, stop_cmd, go;
  logic gnt_vld, push, pop_eff, ovf_set;
  logic [IDX_W-1:0]              gnt_idx, cand;
  logic [31:0]                   fifo_head;
  logic [CNT_W-1:0]              fifo_count;
  logic                          fifo_empty, fifo_full;
  logic                          unused_ok;

  assign hit_nonce  = core_hit_nonce;
  assign reg_addr   = wb_addr[ADDR_W-1:2];
  assign sel_ctrl   = (reg_addr == RA_W'(REG_CTRL >> 2));
  assign sel_status = (reg_addr == RA_W'(REG_STATUS >> 2));
  assign sel_nonce  = (reg_addr == RA_W'(REG_NONCE >> 2));
  assign sel_result = (reg_addr == RA_W'(REG_RESULT >> 2));
  assign mapped     = sel_ctrl | sel_status | sel_nonce | sel_result;

  // A request is taken only when no response is outstanding this cycle
  assign req       = wb_cycle & wb_strobe & ~ack_q & ~err_q;
  assign wr_req    = req & wb_we & mapped;
  assign rd_req    = req & ~wb_we & mapped;
  assign start_cmd = wr_req & sel_ctrl & wb_wdata[CTRL_START];
  assign stop_cmd  = wr_req & sel_ctrl & wb_wdata[CTRL_STOP];
  assign go        = (state_q == S_IDLE) & start_cmd & ~stop_cmd;
  assign pop_eff   = rd_req & sel_result & ~fifo_empty;
  assign unused_ok = ^{wb_sel, wb_addr[1:0]};

  // Controller FSM next state and launch/abort pulses
  always_comb begin
    state_d     = state_q;
    run_first_d = 1'b0;
    start_d     = '0;
    abort_d     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          state_d = S_LAUNCH;
          start_d = '1;
        end
      end
      S_LAUNCH: begin
        state_d     = S_RUN;
        run_first_d = 1'b1;
      end
      S_RUN: begin
        if (stop_cmd) begin
          state_d = S_IDLE;
          abort_d = '1;
        end else if (!run_first_q && core_busy == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register file writes and read-data mux
  always_comb begin
    ack_d         = req & mapped;
    err_d         = req & ~mapped;
    rdata_d       = '0;
    irq_en_d      = irq_en_q;
    nonce_start_d = nonce_start_q;
    base_d        = base_q;
    if (wr_req && sel_ctrl)  irq_en_d = wb_wdata[CTRL_IRQ_EN];
    if (wr_req && sel_nonce) nonce_start_d = wb_wdata;
    if (go) begin
      for (int i = 0; i < NUM_CORES; i++) base_d[i] = nonce_start_q + 32'(i);
    end
    if (rd_req) begin
      if (sel_ctrl) begin
        rdata_d[CTRL_IRQ_EN] = irq_en_q;
      end else if (sel_status) begin
        rdata_d[STAT_RUNNING]        = (state_q != S_IDLE);
        rdata_d[STAT_EMPTY]          = fifo_empty;
        rdata_d[STAT_FULL]           = fifo_full;
        rdata_d[STAT_OVF]            = ovf_q;
        rdata_d[STAT_CNT_LSB +: 8]   = 8'(fifo_count);
      end else if (sel_nonce) begin
        rdata_d = nonce_start_q;
      end else begin
        rdata_d = fifo_empty ? 32'h0 : fifo_head;
      end
    end
    irq_d = irq_en_q & (~fifo_empty | ovf_q);
  end

  // Round-robin pick, searching from the core after the last grant
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand = IDX_W'((int'(rr_q) + k) % int'(NUM_CORES));
      if (!gnt_vld && pend_vld_q[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign push = gnt_vld & (~fifo_full | pop_eff) & ~go;

  // Pending registers: drain the granted entry first, so a core whose entry
  // leaves on this edge can take a new hit without overflowing
  always_comb begin
    pend_vld_d   = pend_vld_q;
    pend_nonce_d = pend_nonce_q;
    rr_d         = rr_q;
    ovf_set      = 1'b0;
    if (push) begin
      pend_vld_d[gnt_idx] = 1'b0;
      rr_d                = gnt_idx;
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_hit[i]) begin
        if (pend_vld_d[i]) begin
          ovf_set = 1'b1;
        end else begin
          pend_vld_d[i]   = 1'b1;
          pend_nonce_d[i] = hit_nonce[i];
        end
      end
    end
    if (go) begin
      pend_vld_d = '0;
      ovf_set    = 1'b0;
    end
    ovf_d = ovf_q;
    if (wr_req && sel_status && wb_wdata[STAT_OVF]) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= S_IDLE;
      run_first_q   <= 1'b0;
      irq_en_q      <= 1'b0;
      nonce_start_q <= '0;
      base_q        <= '0;
      start_q       <= '0;
      abort_q       <= '0;
      ack_q         <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
      irq_q         <= 1'b0;
      ovf_q         <= 1'b0;
      pend_vld_q    <= '0;
      pend_nonce_q  <= '0;
      rr_q          <= '0;
    end else begin
      state_q       <= state_d;
      run_first_q   <= run_first_d;
      irq_en_q      <= irq_en_d;
      nonce_start_q <= nonce_start_d;
      base_q        <= base_d;
      start_q       <= start_d;
      abort_q       <= abort_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      rdata_q       <= rdata_d;
      irq_q         <= irq_d;
      ovf_q         <= ovf_d;
      pend_vld_q    <= pend_vld_d;
      pend_nonce_q  <= pend_nonce_d;
      rr_q          <= rr_d;
    end
  end

  miner_result_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (32)
  ) u_fifo (
    .clk       (clk),
    .arst_n    (arst_n),
    .flush     (go),
    .push      (push),
    .push_data (pend_nonce_q[gnt_idx]),
    .pop       (pop_eff),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign wb_ack          = ack_q;
  assign wb_err          = err_q;
  assign wb_rdata        = rdata_q;
  assign core_start      = start_q;
  assign core_abort      = abort_q;
  assign core_nonce_base = base_q;
  assign irq             = irq_q;

endmodule
